// File: rtl/lex_ctrl_if.sv
// Token output port of lex_ctrl: FWFT FIFO head with ready/valid handshake and occupancy.
interface lex_ctrl_if #(
  parameter int TOK_AW = 4
) ();
  logic              TOK_VALID;
  logic [15:0]       TOK_DATA;
  logic              TOK_READY;
  logic [TOK_AW:0]   TOK_COUNT;

  modport master (output TOK_VALID, output TOK_DATA, output TOK_COUNT, input TOK_READY);
  modport slave  (input TOK_VALID, input TOK_DATA, input TOK_COUNT, output TOK_READY);
endinterface

// File: rtl/lex_ctrl.sv
// Lexer sequencer: clears the lexer, streams source bytes into it under a FIFO-space
// throttle, and buffers emitted tokens in a first-word-fall-through FIFO.
module lex_ctrl #(
  parameter int SRC_AW    = 12,
  parameter int TOK_DEPTH = 16,
  parameter int TOK_AW    = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERROR,
  output logic              SRC_EN,
  output logic [SRC_AW-1:0] SRC_ADDR,
  input  logic [7:0]        SRC_DATA,
  output logic              LEX_RST,
  output logic              LEX_VALID,
  output logic [7:0]        LEX_DATA,
  input  logic              LEX_TOK_VALID,
  input  logic [15:0]       LEX_TOK,
  input  logic              LEX_EOF,
  lex_ctrl_if.master        tok
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FETCH, S_DRAIN, S_DONE} state_t;

  localparam int                CW        = TOK_AW + 2;
  localparam logic [SRC_AW-1:0] ADDR_LAST = '1;

  state_t              state, state_nxt;
  logic                clr_cnt;
  logic [2:0]          drain_cnt;
  logic [3:0]          infl_sr;
  logic [SRC_AW-1:0]   addr;
  logic                err;
  logic                src_vld_p1, last_p1;
  logic                lex_vld_p2;
  logic [7:0]          lex_data_p2;
  logic [15:0]         mem [TOK_DEPTH];
  logic [TOK_AW-1:0]   wr_ptr, rd_ptr;
  logic [TOK_AW:0]     count;
  logic [CW-1:0]       occ_sum;
  logic                start_ok, stop_now, throttle_ok, fetch;
  logic                push, pop, full, drop, push_ok;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  // Fetches issued in the last 4 cycles may still turn into tokens, so reserve room for them.
  assign occ_sum     = CW'(count) + CW'(popcnt4(infl_sr));
  assign throttle_ok = occ_sum <= CW'(TOK_DEPTH - 1);
  assign stop_now    = (src_vld_p1 && (SRC_DATA == 8'h00)) || LEX_EOF;
  assign start_ok    = START && ((state == S_IDLE) || (state == S_DONE));

  always_comb begin
    state_nxt = state;
    fetch     = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (START) state_nxt = S_CLEAR;
      S_CLEAR:        if (clr_cnt) state_nxt = S_FETCH;
      S_FETCH: begin
        fetch = !stop_now && throttle_ok;
        if (stop_now || (fetch && (addr == ADDR_LAST))) state_nxt = S_DRAIN;
      end
      S_DRAIN:        if (!src_vld_p1 && !lex_vld_p2 && (drain_cnt == 3'd5)) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= S_IDLE;
      clr_cnt     <= 1'b0;
      drain_cnt   <= 3'd0;
      infl_sr     <= 4'd0;
      addr        <= '0;
      err         <= 1'b0;
      src_vld_p1  <= 1'b0;
      last_p1     <= 1'b0;
      lex_vld_p2  <= 1'b0;
      lex_data_p2 <= 8'h00;
    end else begin
      state   <= state_nxt;
      clr_cnt <= (state == S_CLEAR) ? ~clr_cnt : 1'b0;
      infl_sr <= {infl_sr[2:0], fetch};
      if ((state != S_DRAIN) || src_vld_p1 || lex_vld_p2) drain_cnt <= 3'd0;
      else if (drain_cnt != 3'd5)                          drain_cnt <= drain_cnt + 3'd1;
      // p1: read data returns from the source RAM
      src_vld_p1 <= fetch;
      last_p1    <= fetch && (addr == ADDR_LAST);
      // p2: registered byte presented to the lexer
      lex_vld_p2 <= src_vld_p1;
      if (src_vld_p1) lex_data_p2 <= SRC_DATA;
      if (start_ok) begin
        addr <= '0;
        err  <= 1'b0;
      end else begin
        if (fetch && (addr != ADDR_LAST)) addr <= addr + SRC_AW'(1);
        if ((last_p1 && (SRC_DATA != 8'h00)) || drop) err <= 1'b1;
      end
    end
  end

  assign push    = LEX_TOK_VALID && (state inside {S_FETCH, S_DRAIN, S_DONE});
  assign full    = (count == (TOK_AW+1)'(TOK_DEPTH));
  assign pop     = tok.TOK_VALID && tok.TOK_READY;
  assign drop    = push && full && !pop;
  assign push_ok = push && !drop;

  always_ff @(posedge CLK) begin
    if (!RST || start_ok) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + TOK_AW'(1);
      if (pop)     rd_ptr <= rd_ptr + TOK_AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (TOK_AW+1)'(1);
        2'b01:   count <= count - (TOK_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= LEX_TOK;
  end

  assign tok.TOK_VALID = (count != '0);
  assign tok.TOK_DATA  = mem[rd_ptr];
  assign tok.TOK_COUNT = count;

  assign BUSY      = (state == S_CLEAR) || (state == S_FETCH) || (state == S_DRAIN);
  assign DONE      = (state == S_DONE);
  assign ERROR     = err;
  assign SRC_EN    = fetch;
  assign SRC_ADDR  = addr;
  assign LEX_RST   = !RST || (state == S_CLEAR);
  assign LEX_VALID = lex_vld_p2;
  assign LEX_DATA  = lex_data_p2;

endmodule

// File: doc/lex_ctrl.md
# lex_ctrl

Sequencer for the token lexer. It clears the lexer, streams source bytes from a synchronous source RAM into it, and collects the emitted 16-bit tokens into an internal FIFO drained through a ready/valid port. It signals completion once the lexer reports EOF or the source terminator has been consumed. It sits between the source BRAM and the parser/evaluator stage, and it throttles fetch because the lexer itself has no stall.

## Interface

Parameters:
- SRC_AW, 12, source RAM address width in bytes.
- TOK_DEPTH, 16, token FIFO depth; power of two, ≥ 8.
- TOK_AW, 4, log2(TOK_DEPTH).

Ports:
- CLK  in  1  clock. One clock domain; all logic is synchronous to it.
- RST  in  1  synchronous, active-low reset.
- START  in  1  one-cycle start pulse; ignored unless in IDLE or DONE.
- BUSY  out  1  high in CLEAR, FETCH and DRAIN.
- DONE  out  1  high in DONE state; held until the next START.
- ERROR  out  1  sticky until next START: source ran out without a 0x00 terminator, or a token was dropped.
- SRC_EN  out  1  source RAM read enable.
- SRC_ADDR  out  SRC_AW  source read address.
- SRC_DATA  in  8  read data, valid one cycle after SRC_EN.
- LEX_RST  out  1  active-high reset to the lexer.
- LEX_VALID  out  1  lexer byte strobe.
- LEX_DATA  out  8  lexer byte.
- LEX_TOK_VALID  in  1  token strobe from the lexer.
- LEX_TOK  in  16  token from the lexer, {tag[15:8], value[7:0]}.
- LEX_EOF  in  1  lexer sticky EOF flag.
- TOK_VALID  out  1  FIFO not empty.
- TOK_DATA  out  16  FIFO head, shown first-word-fall-through.
- TOK_READY  in  1  consumer accepts the head when TOK_VALID is also high.
- TOK_COUNT  out  TOK_AW+1  current FIFO occupancy.

## Operation

States: IDLE → CLEAR → FETCH → DRAIN → DONE.

- **IDLE.** START moves to CLEAR. At the same time: clear ERROR, set the address to 0, flush the FIFO.
- **CLEAR.** LEX_RST is high for exactly 2 cycles, then the block moves to FETCH. No fetches are issued.
- **FETCH.**
  - Each cycle, issue SRC_EN=1 at the current SRC_ADDR, then increment the address.
  - Fetch is allowed only when TOK_COUNT + inflight ≤ TOK_DEPTH−1. Here inflight is the number of fetches issued in the previous 4 cycles (a 4-bit shift register of SRC_EN).
  - When SRC_DATA returns, it is registered. LEX_VALID and LEX_DATA are asserted the following cycle.
  - Every returned byte is forwarded to the lexer, including the terminator.
  - Leave to DRAIN on any of the following:
    - a returned byte equal to 0x00;
    - LEX_EOF high;
    - a fetch issued at address 2^SRC_AW−1 (last address). If no 0x00 byte is returned for it, set ERROR.
  - Once the exit condition is detected, no further fetches are issued. Bytes already in flight are still forwarded.
- **DRAIN.**
  - No fetch is issued.
  - Wait 6 cycles after the last LEX_VALID so in-flight tokens can land, then move to DONE.
- **DONE.** DONE=1. The FIFO keeps draining. START re-enters CLEAR, flushing the FIFO and clearing DONE and ERROR.

Token FIFO:
- Every LEX_TOK_VALID cycle pushes LEX_TOK, in any state except IDLE and CLEAR.
- If a push arrives while the FIFO is full, the token is dropped and ERROR is set. The throttle rule makes this unreachable in normal operation.
- Pop occurs when TOK_VALID && TOK_READY.
- Simultaneous push and pop on a full FIFO: both occur, nothing is dropped, and occupancy is unchanged.
- Simultaneous push and pop on an empty FIFO: the push occurs and the pop is a no-op, because TOK_VALID is low.
- Pointers are TOK_AW bits and wrap modulo TOK_DEPTH. Occupancy is TOK_AW+1 bits.

## Timing

Reset (RST=0 at a clock edge):
- State goes to IDLE.
- BUSY, DONE, ERROR, SRC_EN, LEX_VALID, TOK_VALID = 0.
- SRC_ADDR = 0, LEX_DATA = 0, TOK_COUNT = 0.
- LEX_RST = 1 while RST is low, and 0 after reset.
- Reset mid-operation aborts immediately. The FIFO contents are discarded.

Latencies:
- START to first SRC_EN: 3 cycles (1 cycle into CLEAR, then 2 CLEAR cycles).
- SRC_EN at cycle t → SRC_DATA at t+1 → LEX_VALID at t+2.
- A delimiter byte sent at cycle t produces its token at LEX_TOK_VALID t+2. It is pushed at t+3 and visible on TOK_VALID at t+3.

Handshake and status rules:
- TOK_DATA is stable while TOK_VALID && !TOK_READY.
- START while BUSY is ignored.
- BUSY and DONE are never high together.

## Test plan

- **Basic run.** Source "12 + 3 EOF\0" with TOK_READY held at 1 → tokens in order 0x000C, 0x0100, 0x0003, 0x0300. DONE rises; ERROR = 0.
- **Back-pressure.** Same source, but TOK_READY stays 0 until DONE → TOK_COUNT never exceeds 16, no drop, ERROR = 0. Releasing TOK_READY then yields the same 4 tokens in order.
- **Throttle at full.** Source of 40 tokens "1 1 1 …", TOK_READY low → fetch stalls with TOK_COUNT + inflight ≤ 15. Releasing TOK_READY resumes fetch; all 40 tokens delivered.
- **Missing terminator.** With SRC_AW=4, 16 bytes of "+ + + + …" and no 0x00 → SRC_ADDR stops after 15, ERROR = 1, DONE = 1.
- **Reset mid-run.** Assert RST=0 during FETCH → next cycle all outputs are at reset values and TOK_COUNT = 0. A subsequent START produces a correct run.
- **Restart from DONE.** START in DONE → DONE and ERROR clear, LEX_RST pulses for 2 cycles, and fetching restarts at address 0.
